// File: rtl/mdu_pkg.sv
// mdu_pkg: shared types and constants for the multiply/divide unit.
//   div_state_t : divider FSM state encoding (IDLE, CALC, DONE)
//   MDU_WIDTH   : default operand width
//   MDU_CNT_W   : iteration counter width, wide enough to hold MDU_WIDTH
package mdu_pkg;

  localparam int MDU_WIDTH = 32;
  localparam int MDU_CNT_W = $clog2(MDU_WIDTH + 1);

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_CALC = 2'd1,
    DIV_DONE = 2'd2
  } div_state_t;

endpackage

// File: rtl/mdu_div_step.sv
// mdu_div_step: one combinational radix-2 restoring division iteration.
// Kept as its own block so it can be chained for a higher-radix variant.
// Ports:
//   rem       in  WIDTH+1  current partial remainder
//   qreg      in  WIDTH    dividend/quotient shift register
//   divisor   in  WIDTH    divisor magnitude
//   rem_next  out WIDTH+1  partial remainder after this iteration
//   qreg_next out WIDTH    shift register after this iteration
module mdu_div_step
  import mdu_pkg::*;
#(
  parameter int WIDTH = MDU_WIDTH
) (
  input  logic [WIDTH:0]   rem,
  input  logic [WIDTH-1:0] qreg,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH:0]   rem_next,
  output logic [WIDTH-1:0] qreg_next
);

  logic [WIDTH:0]   partial;
  logic [WIDTH+1:0] trial;
  logic             fits;

  // The MSB of the remainder is always shifted out by the next partial,
  // so it never influences the result.
  logic unused_rem_msb;
  assign unused_rem_msb = rem[WIDTH];

  assign partial = {rem[WIDTH-1:0], qreg[WIDTH-1]};

  // One extra bit on the subtraction so its sign is the borrow out.
  assign trial = {1'b0, partial} - {2'b00, divisor};
  assign fits  = ~trial[WIDTH+1];

  assign rem_next  = fits ? trial[WIDTH:0] : partial;
  assign qreg_next = {qreg[WIDTH-2:0], fits};

endmodule

// File: rtl/mdu_div.sv
// mdu_div: iterative radix-2 restoring divider for MIPS DIV/DIVU.
// One quotient bit per cycle; quotient feeds LO, remainder feeds HI.
// Optional macro MDU_DIV_ZERO_FAST_EN: a zero divisor skips the iterations
// and goes straight to DONE with the (identical) divide-by-zero result.
// Ports:
//   clk        in   clock, rising edge
//   resetn     in   synchronous active-low reset
//   cancel     in   flush; returns the block to IDLE from any state
//   in_valid   in   operands present
//   in_ready   out  high only in IDLE
//   in_signed  in   1 = DIV, 0 = DIVU
//   dividend   in   WIDTH numerator
//   divisor    in   WIDTH denominator
//   out_valid  out  result available (DONE)
//   out_ready  in   consumer takes the result
//   quotient   out  WIDTH sign-corrected quotient
//   remainder  out  WIDTH sign-corrected remainder
//   busy       out  high in CALC or DONE
//
// state | meaning
// IDLE  | waiting for operands, in_ready high
// CALC  | running WIDTH restoring iterations
// DONE  | result held until out_ready handshake
module mdu_div
  import mdu_pkg::*;
#(
  parameter int WIDTH = MDU_WIDTH
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             cancel,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             busy
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  div_state_t       state;
  logic [WIDTH:0]   rem;
  logic [WIDTH-1:0] qreg;
  logic [WIDTH-1:0] dvsr;
  logic [CNT_W-1:0] cnt;
  logic             q_neg;
  logic             r_neg;

  logic [WIDTH:0]   rem_next;
  logic [WIDTH-1:0] qreg_next;
  logic [WIDTH-1:0] dividend_abs;
  logic [WIDTH-1:0] divisor_abs;
  logic             accept;

  assign accept = in_valid & (state == DIV_IDLE) & ~cancel;

  // Magnitudes are only taken for signed divides; 0x80000000 wraps to
  // itself, which is the correct unsigned magnitude.
  assign dividend_abs = (in_signed & dividend[WIDTH-1]) ? -dividend : dividend;
  assign divisor_abs  = (in_signed & divisor[WIDTH-1])  ? -divisor  : divisor;

  mdu_div_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .rem      (rem),
    .qreg     (qreg),
    .divisor  (dvsr),
    .rem_next (rem_next),
    .qreg_next(qreg_next)
  );

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state <= DIV_IDLE;
      rem   <= '0;
      qreg  <= '0;
      dvsr  <= '0;
      cnt   <= '0;
      q_neg <= 1'b0;
      r_neg <= 1'b0;
    end else begin
      unique case (state)
        DIV_IDLE: begin
          if (accept) begin
            qreg  <= dividend_abs;
            dvsr  <= divisor_abs;
            rem   <= '0;
            cnt   <= '0;
            q_neg <= in_signed & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
            r_neg <= in_signed & dividend[WIDTH-1];
            state <= DIV_CALC;
`ifdef MDU_DIV_ZERO_FAST_EN
            // Same values the iterations would converge to: every trial
            // fits, so the quotient is all ones and the dividend ends up
            // in the remainder.
            if (divisor == '0) begin
              qreg  <= '1;
              rem   <= {1'b0, dividend_abs};
              cnt   <= CNT_W'(WIDTH);
              state <= DIV_DONE;
            end
`endif
          end
        end
        DIV_CALC: begin
          rem  <= rem_next;
          qreg <= qreg_next;
          cnt  <= cnt + CNT_W'(1);
          if (cnt == CNT_W'(WIDTH - 1)) begin
            state <= DIV_DONE;
          end
        end
        DIV_DONE: begin
          if (out_ready) begin
            state <= DIV_IDLE;
          end
        end
        default: state <= DIV_IDLE;
      endcase

      if (cancel) begin
        state <= DIV_IDLE;
      end
    end
  end

  assign in_ready  = (state == DIV_IDLE);
  assign out_valid = (state == DIV_DONE);
  assign busy      = (state == DIV_CALC) | (state == DIV_DONE);

  assign quotient  = q_neg ? -qreg : qreg;
  assign remainder = r_neg ? -rem[WIDTH-1:0] : rem[WIDTH-1:0];

endmodule

// File: tb/tb_mdu_div.sv
module tb_mdu_div;

  localparam int W = 32;

`ifdef MDU_DIV_ZERO_FAST_EN
  localparam int ZERO_LAT = 0;
`else
  localparam int ZERO_LAT = 32;
`endif

  logic         clk = 1'b0;
  logic         resetn;
  logic         cancel;
  logic         in_valid;
  logic         in_ready;
  logic         in_signed;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         busy;

  int checks = 0;
  int errors = 0;

  mdu_div #(.WIDTH(W)) dut (
    .clk      (clk),
    .resetn   (resetn),
    .cancel   (cancel),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_signed(in_signed),
    .dividend (dividend),
    .divisor  (divisor),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .quotient (quotient),
    .remainder(remainder),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%h expected=0x%h", tag, obs, exp);
    end
  endtask

  // Reference: MIPS semantics with plain integer arithmetic plus the
  // defined divide-by-zero and overflow cases.
  function automatic void ref_div(input bit s, input logic [W-1:0] a, input logic [W-1:0] b,
                                  output logic [W-1:0] q, output logic [W-1:0] r);
    int sa;
    int sb;
    if (b == 0) begin
      q = (s && a[W-1]) ? 32'h0000_0001 : 32'hFFFF_FFFF;
      r = a;
    end else if (!s) begin
      q = a / b;
      r = a % b;
    end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      q = 32'h8000_0000;
      r = 32'h0;
    end else begin
      sa = a;
      sb = b;
      q = sa / sb;
      r = sa % sb;
    end
  endfunction

  // Issue one divide from a negedge, wait for the result, hold it for
  // 'hold' cycles with out_ready low, then hand it off.
  task automatic do_div(input bit s, input logic [W-1:0] a, input logic [W-1:0] b,
                        input int hold, input string tag);
    logic [W-1:0] eq;
    logic [W-1:0] er;
    int edges;
    ref_div(s, a, b, eq, er);
    chk({tag, " in_ready idle"}, W'(in_ready), 1);
    in_valid  = 1'b1;
    in_signed = s;
    dividend  = a;
    divisor   = b;
    @(negedge clk);
    in_valid  = 1'b0;
    dividend  = $urandom;
    divisor   = $urandom;
    in_signed = 1'($urandom);
    edges = 0;
    while (!out_valid && edges < 100) begin
      @(negedge clk);
      edges++;
    end
    chk({tag, " latency"}, W'(edges), (b == 0) ? W'(ZERO_LAT) : 32);
    chk({tag, " quotient"}, quotient, eq);
    chk({tag, " remainder"}, remainder, er);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk({tag, " hold out_valid"}, W'(out_valid), 1);
      chk({tag, " hold quotient"}, quotient, eq);
      chk({tag, " hold remainder"}, remainder, er);
      chk({tag, " hold in_ready"}, W'(in_ready), 0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk({tag, " after hs out_valid"}, W'(out_valid), 0);
    chk({tag, " after hs in_ready"}, W'(in_ready), 1);
    chk({tag, " after hs busy"}, W'(busy), 0);
  endtask

  initial begin
    int seen;
    bit rs;
    logic [W-1:0] ra;
    logic [W-1:0] rb;

    resetn    = 1'b0;
    cancel    = 1'b0;
    in_valid  = 1'b0;
    in_signed = 1'b0;
    dividend  = '0;
    divisor   = '0;
    out_ready = 1'b0;
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    chk("reset in_ready", W'(in_ready), 1);
    chk("reset out_valid", W'(out_valid), 0);
    chk("reset busy", W'(busy), 0);
    chk("reset quotient", quotient, 0);
    chk("reset remainder", remainder, 0);

    do_div(1'b0, 32'd100, 32'd7, 0, "divu_100_7");
    do_div(1'b1, 32'hFFFF_FFF9, 32'd2, 0, "div_m7_2");
    do_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 0, "div_ovf");
    do_div(1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 0, "divu_ovf");
    do_div(1'b1, 32'hFFFF_FFF0, 32'd0, 0, "div_by0_neg");
    do_div(1'b1, 32'd1234, 32'd0, 0, "div_by0_pos");
    do_div(1'b0, 32'hDEAD_BEEF, 32'd0, 0, "divu_by0");
    do_div(1'b1, 32'd77, 32'hFFFF_FFF6, 5, "hold5");

    // Cancel on the 10th CALC cycle: the result must never appear.
    in_valid  = 1'b1;
    in_signed = 1'b0;
    dividend  = 32'd1000;
    divisor   = 32'd3;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (9) @(negedge clk);
    cancel = 1'b1;
    @(negedge clk);
    cancel = 1'b0;
    chk("cancel calc in_ready", W'(in_ready), 1);
    chk("cancel calc out_valid", W'(out_valid), 0);
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    chk("cancel calc no result", W'(seen), 0);
    do_div(1'b0, 32'd9, 32'd3, 0, "post_cancel");

    // Cancel in the same cycle as a would-be accept drops the operands.
    in_valid = 1'b1;
    cancel   = 1'b1;
    dividend = 32'd50;
    divisor  = 32'd5;
    @(negedge clk);
    in_valid = 1'b0;
    cancel   = 1'b0;
    chk("cancel accept in_ready", W'(in_ready), 1);
    chk("cancel accept busy", W'(busy), 0);

    // Cancel in DONE wins over out_ready.
    in_valid  = 1'b1;
    in_signed = 1'b0;
    dividend  = 32'd81;
    divisor   = 32'd9;
    @(negedge clk);
    in_valid = 1'b0;
    seen = 0;
    while (!out_valid && seen < 100) begin
      @(negedge clk);
      seen++;
    end
    chk("cancel done reached", W'(out_valid), 1);
    cancel    = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    cancel    = 1'b0;
    out_ready = 1'b0;
    chk("cancel done out_valid", W'(out_valid), 0);
    chk("cancel done in_ready", W'(in_ready), 1);

    // Reset mid-operation clears the registers as well as the state.
    in_valid  = 1'b1;
    in_signed = 1'b1;
    dividend  = 32'hFFFF_0000;
    divisor   = 32'd17;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (5) @(negedge clk);
    resetn = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    chk("midreset quotient", quotient, 0);
    chk("midreset remainder", remainder, 0);
    chk("midreset in_ready", W'(in_ready), 1);
    chk("midreset busy", W'(busy), 0);

    for (int n = 0; n < 24; n++) begin
      rs = 1'($urandom);
      ra = $urandom;
      case ($urandom_range(0, 3))
        0:       rb = $urandom;
        1:       rb = 32'($urandom_range(1, 255));
        2:       rb = -32'($urandom_range(1, 255));
        default: rb = (n % 8 == 3) ? 32'd0 : 32'($urandom_range(1, 65535));
      endcase
      do_div(rs, ra, rb, $urandom_range(0, 2), $sformatf("rand%0d", n));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
